// File: rtl/colpar_ctrl.sv
// colpar_ctrl: sequencer for the column-parity datapath.
// For each depth slice it loads one line, streams LANES parity bits to the
// file writer, stores the slice as the previous depth and moves to the next one.
// It also provides a start/done handshake and abort. A shadow lane counter
// cross-checks the counter25 carry-out.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, abort              run request (IDLE only), cancel (LOAD/COMP/SAVE)
//   ready, busy, done, err    status: idle, running, end pulse, sticky carry mismatch
//   ld_fr, ld_r, en_fw        file reader load, prev-depth capture, file writer append
//   init0_c64/c25, en_c64/c25 counter clears and increments
//   co_c64, co_c25            counter carry-outs from the datapath
module colpar_ctrl #(
    parameter int unsigned DEPTHS = 64,
    parameter int unsigned LANES  = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic ready,
    output logic busy,
    output logic done,
    output logic err,
    output logic ld_fr,
    output logic ld_r,
    output logic en_fw,
    output logic init0_c64,
    output logic init0_c25,
    output logic en_c64,
    output logic en_c25,
    input  logic co_c64,
    input  logic co_c25
);

    localparam int unsigned SW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [SW-1:0] LAST_LANE = SW'(LANES - 1);

    // The slice count lives in the datapath (co_c64). The parameter is kept
    // here so that a degenerate configuration is rejected at elaboration.
    if (DEPTHS < 1 || LANES < 2) begin : g_param_check
        $error("colpar_ctrl: DEPTHS must be >= 1 and LANES >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_COMP,
        S_SAVE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] shadow_q, shadow_d;
    logic          err_q, err_d;
    logic          lane_last;

    assign lane_last = (shadow_q == LAST_LANE);

    // State, shadow lane counter and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    // Next-state and Moore output decode. Reset forces every output low.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        err_d     = err_q;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        ld_fr     = 1'b0;
        ld_r      = 1'b0;
        en_fw     = 1'b0;
        init0_c64 = 1'b0;
        init0_c25 = 1'b0;
        en_c64    = 1'b0;
        en_c25    = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready    = 1'b1;
                shadow_d = '0;
                if (start) begin
                    state_d = S_INIT;
                    err_d   = 1'b0;
                end
            end
            S_INIT: begin
                busy      = 1'b1;
                init0_c64 = 1'b1;
                init0_c25 = 1'b1;
                shadow_d  = '0;
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                busy    = 1'b1;
                ld_fr   = 1'b1;
                state_d = abort ? S_DONE : S_COMP;
            end
            S_COMP: begin
                busy     = 1'b1;
                en_fw    = 1'b1;
                en_c25   = 1'b1;
                shadow_d = shadow_q + SW'(1);
                // The datapath carry must agree with the shadow count on every lane.
                if (co_c25 != lane_last) begin
                    err_d = 1'b1;
                end
                // Abort takes priority over the last-lane exit, so no SAVE follows.
                if (abort) begin
                    state_d = S_DONE;
                end else if (lane_last) begin
                    state_d = S_SAVE;
                end
            end
            S_SAVE: begin
                busy      = 1'b1;
                ld_r      = 1'b1;
                en_c64    = 1'b1;
                init0_c25 = 1'b1;
                shadow_d  = '0;
                state_d   = (abort || co_c64) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done     = 1'b1;
                shadow_d = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rst) begin
            ready     = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
            ld_fr     = 1'b0;
            ld_r      = 1'b0;
            en_fw     = 1'b0;
            init0_c64 = 1'b0;
            init0_c25 = 1'b0;
            en_c64    = 1'b0;
            en_c25    = 1'b0;
        end
    end

    assign err = err_q & ~rst;

endmodule

// File: tb/tb_colpar_ctrl.sv
// Testbench for colpar_ctrl. The expected result of each run is queued when the
// run is started, and a monitor checks it against the DUT when done appears.
module tb_colpar_ctrl;

    localparam int unsigned DEPTHS = 64;
    localparam int unsigned LANES  = 25;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic ready, busy, done, err, ld_fr, ld_r, en_fw;
    logic init0_c64, init0_c25, en_c64, en_c25, co_c64, co_c25;

    colpar_ctrl #(.DEPTHS(DEPTHS), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ready(ready), .busy(busy), .done(done), .err(err),
        .ld_fr(ld_fr), .ld_r(ld_r), .en_fw(en_fw),
        .init0_c64(init0_c64), .init0_c25(init0_c25),
        .en_c64(en_c64), .en_c25(en_c25),
        .co_c64(co_c64), .co_c25(co_c25)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal datapath counters, with an optional forced carry on lane 10 of slice 3.
    int unsigned c64 = 0;
    int unsigned c25 = 0;
    logic force_en = 1'b0;
    always @(posedge clk) begin
        if (init0_c64)   c64 <= 0;
        else if (en_c64) c64 <= (c64 == DEPTHS - 1) ? 0 : c64 + 1;
        if (init0_c25)   c25 <= 0;
        else if (en_c25) c25 <= (c25 == LANES - 1) ? 0 : c25 + 1;
    end
    assign co_c64 = (c64 == DEPTHS - 1);
    assign co_c25 = (c25 == LANES - 1) || (force_en && c64 == 3 && c25 == 10);

    typedef struct {
        int   delta;
        int   n_fr;
        int   n_fw;
        int   n_r;
        logic err;
    } exp_t;
    exp_t sb_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Monitor: per-cycle protocol checks and scoreboard compare on done.
    int   run_start = 0;
    int   n_fr = 0, n_fw = 0, n_r = 0, fw_run = 0, mutex_bad = 0, dones = 0;
    logic prev_fr = 1'b0, prev_done = 1'b0, prev_force_hit = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_outputs", 32'({ready, busy, done, err, ld_fr, ld_r, en_fw,
                                     init0_c64, init0_c25, en_c64, en_c25}), 32'd0);
            fw_run         = 0;
            prev_fr        = 1'b0;
            prev_done      = 1'b0;
            prev_force_hit = 1'b0;
        end else begin
            if ((ld_fr && en_fw) || (init0_c25 && en_c25) || (init0_c64 && en_c64)
                || (en_fw != en_c25)) mutex_bad++;
            if (prev_force_hit) chk("err_after_force", 32'(err), 32'd1);
            prev_force_hit = force_en && en_fw && c64 == 3 && c25 == 10;
            if (prev_done) chk("done_one_cycle", 32'({done, ready}), 32'd1);
            prev_done = done;
            if (init0_c64) begin
                run_start = cyc - 1;
                n_fr = 0; n_fw = 0; n_r = 0;
                chk("err_cleared_at_start", 32'(err), 32'd0);
            end
            if (ld_fr) n_fr++;
            if (en_fw) begin
                n_fw++;
                fw_run++;
                if (fw_run == 1) chk("load_before_comp", 32'(prev_fr), 32'd1);
            end
            if (ld_r) begin
                n_r++;
                chk("slice_lanes", 32'(fw_run), 32'(LANES));
                chk("save_ctrl", 32'({en_c64, init0_c25, en_fw}), 32'd6);
            end
            if (!en_fw) fw_run = 0;
            prev_fr = ld_fr;
            if (done) begin
                dones++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_cycle", 32'(cyc - run_start), 32'(e.delta));
                    chk("ld_fr_count", 32'(n_fr), 32'(e.n_fr));
                    chk("en_fw_count", 32'(n_fw), 32'(e.n_fw));
                    chk("ld_r_count", 32'(n_r), 32'(e.n_r));
                    chk("err_at_done", 32'(err), 32'(e.err));
                end
            end
        end
    end

    task automatic start_run(input exp_t e);
        @(posedge clk);
        #2 start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (dones == d0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (dones == d0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        exp_t e_norm, e_err, e_abort;
        int   d0;
        int   t;
        e_norm  = '{delta: 1730, n_fr: 64, n_fw: 1600, n_r: 64, err: 1'b0};
        e_err   = '{delta: 1730, n_fr: 64, n_fw: 1600, n_r: 64, err: 1'b1};
        e_abort = '{delta: 150,  n_fr: 6,  n_fw: 137,  n_r: 5,  err: 1'b0};

        // Reset held with start high.
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'({ready, busy}), 32'd2);

        // Normal run.
        d0 = dones; start_run(e_norm); wait_done(d0);

        // Forced carry mismatch: err sets, run still completes on time.
        force_en = 1'b1;
        d0 = dones; start_run(e_err); wait_done(d0);
        force_en = 1'b0;

        // Abort in the 137th streaming cycle (slice 5).
        d0 = dones; start_run(e_abort);
        t = 0;
        while (t < 2000) begin
            @(posedge clk); #1;
            if (n_fw == 136 && en_fw) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                break;
            end
            t++;
        end
        wait_done(d0);

        // Reset in the middle of slice 20, then a clean restart.
        d0 = dones; start_run(e_norm);
        t = 0;
        while (t < 2000 && !(n_r == 20 && en_fw)) begin
            @(posedge clk); #1;
            t++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        #1 chk("ready_after_mid_rst", 32'({ready, busy, en_fw}), 32'd4);
        chk("no_done_after_rst", 32'(dones), 32'(d0));
        d0 = dones; start_run(e_norm); wait_done(d0);

        repeat (3) @(posedge clk);
        chk("output_exclusion", 32'(mutex_bad), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
